// File: rtl/chime_alarm_ctrl.sv
// Hourly pip/long-tone chime plus daily alarm, driving a single buzzer pin.
// Consumes binary h/m/s from the timekeeping counters; buzz is a registered square wave or 0.
module chime_alarm_ctrl #(
  parameter int unsigned DIV_LO    = 62500,
  parameter int unsigned DIV_HI    = 50000,
  parameter int unsigned N_PIPS    = 5,
  parameter int unsigned LONG_SEC  = 1,
  parameter int unsigned ALARM_SEC = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] H_in,
  input  logic [5:0] M_in,
  input  logic [5:0] S_in,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  input  logic       stop,
  output logic       buzz,
  output logic       alarm_active,
  output logic       busy
);

  localparam int unsigned LO_W  = (DIV_LO > 1) ? $clog2(DIV_LO) : 1;
  localparam int unsigned HI_W  = (DIV_HI > 1) ? $clog2(DIV_HI) : 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PIP   = 2'd1;
  localparam logic [1:0] ST_LONG  = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  // First pip second of minute 59; pips then fall on every even second up to 58.
  localparam logic [5:0] PIP_FIRST = 6'(60 - 2 * N_PIPS);
  localparam logic [5:0] PIP_LAST  = 6'd58;

  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_SEC - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_SEC - 1);
  localparam logic [LO_W-1:0]  LO_WRAP    = LO_W'(DIV_LO - 1);
  localparam logic [HI_W-1:0]  HI_WRAP    = HI_W'(DIV_HI - 1);

  // Elaboration-time parameter range guards.
  if (N_PIPS < 1 || N_PIPS > 29) begin : g_bad_pips
    $error("chime_alarm_ctrl: N_PIPS must be 1..29");
  end
  if (LONG_SEC < 1 || LONG_SEC > 59) begin : g_bad_long
    $error("chime_alarm_ctrl: LONG_SEC must be 1..59");
  end
  if (ALARM_SEC < 1 || ALARM_SEC > 255) begin : g_bad_alarm
    $error("chime_alarm_ctrl: ALARM_SEC must be 1..255");
  end
  if (DIV_LO < 1 || DIV_HI < 1) begin : g_bad_div
    $error("chime_alarm_ctrl: tone dividers must be >= 1");
  end

  logic [LO_W-1:0]  lo_cnt_q;
  logic             lo_tone_q;
  logic [HI_W-1:0]  hi_cnt_q;
  logic             hi_tone_q;

  logic [5:0]       sec_q;
  logic             armed_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic             buzz_q, buzz_d;
  logic             alarm_active_q, alarm_active_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             alarm_hit;
  logic             pip_hit;
  logic             long_hit;
  logic [1:0]       ev_state;

  // Free-running low ("doo") tone divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_cnt_q  <= '0;
      lo_tone_q <= 1'b0;
    end else if (lo_cnt_q == LO_WRAP) begin
      lo_cnt_q  <= '0;
      lo_tone_q <= ~lo_tone_q;
    end else begin
      lo_cnt_q  <= lo_cnt_q + 1'b1;
    end
  end

  // Free-running high ("di") tone divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_q  <= '0;
      hi_tone_q <= 1'b0;
    end else if (hi_cnt_q == HI_WRAP) begin
      hi_cnt_q  <= '0;
      hi_tone_q <= ~hi_tone_q;
    end else begin
      hi_cnt_q  <= hi_cnt_q + 1'b1;
    end
  end

  // armed_q masks the first post-reset cycle so a cleared sec_q does not replay an event.
  assign tick      = armed_q && (S_in != sec_q);
  assign alarm_hit = alarm_en && (H_in == alarm_h) && (M_in == alarm_m) && (S_in == 6'd0);
  assign pip_hit   = chime_en && (M_in == 6'd59) && !S_in[0]
                     && (S_in >= PIP_FIRST) && (S_in <= PIP_LAST);
  assign long_hit  = chime_en && (M_in == 6'd0) && (S_in == 6'd0);

  // State, second bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q          <= '0;
      armed_q        <= 1'b0;
      state_q        <= ST_IDLE;
      sec_cnt_q      <= '0;
      buzz_q         <= 1'b0;
      alarm_active_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sec_q          <= S_in;
      armed_q        <= 1'b1;
      state_q        <= state_d;
      sec_cnt_q      <= sec_cnt_d;
      buzz_q         <= buzz_d;
      alarm_active_q <= alarm_active_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    sec_cnt_d      = sec_cnt_q;
    buzz_d         = 1'b0;
    ev_state       = ST_IDLE;

    if (alarm_hit) begin
      ev_state = ST_ALARM;
    end else if (pip_hit) begin
      ev_state = ST_PIP;
    end else if (long_hit) begin
      ev_state = ST_LONG;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d   = ev_state;
          sec_cnt_d = '0;
        end
      end
      ST_PIP: begin
        buzz_d = hi_tone_q;
        if (tick) begin
          state_d   = ev_state;
          sec_cnt_d = '0;
        end else if (!chime_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_LONG: begin
        buzz_d = lo_tone_q;
        if (tick && alarm_hit) begin
          state_d   = ST_ALARM;
          sec_cnt_d = '0;
        end else if (!chime_en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (sec_cnt_q == LONG_LAST) begin
            state_d = ST_IDLE;
          end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
          end
        end
      end
      ST_ALARM: begin
        // 1 s on / 1 s off, keyed off the elapsed-second count.
        buzz_d = hi_tone_q & ~sec_cnt_q[0];
        if (stop || !alarm_en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (sec_cnt_q == ALARM_LAST) begin
            state_d = ST_IDLE;
          end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    alarm_active_d = (state_d == ST_ALARM);
    busy_d         = (state_d != ST_IDLE);
  end

  assign buzz         = buzz_q;
  assign alarm_active = alarm_active_q;
  assign busy         = busy_q;

endmodule

// File: doc/chime_alarm_ctrl.md
Name: chime_alarm_ctrl

Overview:
- Parametrised successor to the hourly chime buzzer.
- Produces the top-of-hour pip sequence: N short high-pitch pips in the last seconds of minute 59, then a configurable long low-pitch tone at hh:00:00.
- Adds a programmable daily alarm with a beep pattern, stop/acknowledge, chime enable, and a defined idle level (buzz low).
- Sits between the timekeeping counters (hour/minute/second in binary) and the buzzer pin.

Parameters:
- DIV_LO, 62500, clk cycles per half-period of the low ("doo") tone; f = f_clk/(2*DIV_LO).
- DIV_HI, 50000, clk cycles per half-period of the high ("di") tone.
- N_PIPS, 5, number of pre-hour pips, 1..29; pips occur at second 60-2k of minute 59, for k = N_PIPS down to 1.
- LONG_SEC, 1, duration in seconds of the low tone at hh:00:00, 1..59.
- ALARM_SEC, 60, maximum alarm duration in seconds, 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- H_in  in  5  current hour, binary 0..23
- M_in  in  6  current minute, binary 0..59
- S_in  in  6  current second, binary 0..59
- chime_en  in  1  1 = hourly chime enabled
- alarm_en  in  1  1 = alarm armed
- alarm_h  in  5  alarm hour, binary 0..23
- alarm_m  in  6  alarm minute, binary 0..59
- stop  in  1  single-cycle pulse; silences an active alarm
- buzz  out  1  buzzer drive, square wave or 0
- alarm_active  out  1  high while in ALARM
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - buzz=0, alarm_active=0, busy=0, state=IDLE.
  - Both tone dividers and both tone flops clear to 0.
  - sec_q and the second counter clear to 0.
- Tone generators:
  - Free-running; reset only by rst_n.
  - Each counter counts 0..DIV-1; at DIV-1 it wraps to 0 and toggles its tone flop. The low tone has period 2*DIV_LO clk cycles.
  - Counter width is $clog2(DIV).
- Second tick:
  - sec_q registers S_in each cycle.
  - tick = (S_in != sec_q), a 1-cycle pulse at each second boundary.
  - Event decode is evaluated only on the tick cycle, using the new S_in.
- States: IDLE, PIP, LONG, ALARM.
- IDLE:
  - On tick, if alarm_en && H_in==alarm_h && M_in==alarm_m && S_in==0: go to ALARM, sec_cnt=0. Alarm has priority over the chime.
  - Else, if chime_en && M_in==59 && S_in==60-2k for some k in 1..N_PIPS: go to PIP.
  - Else, if chime_en && M_in==0 && S_in==0: go to LONG, sec_cnt=0.
- PIP:
  - buzz = high tone.
  - On the next tick: re-evaluate the IDLE decode (an even second can go directly to LONG or ALARM); otherwise go to IDLE. Each pip therefore lasts exactly one second.
- LONG:
  - buzz = low tone.
  - Each tick increments sec_cnt; when sec_cnt reaches LONG_SEC-1, go to IDLE on that tick.
  - If the alarm condition matches on a tick, go to ALARM.
- ALARM:
  - buzz = high tone while sec_cnt[0]==0, otherwise 0 (1 s on / 1 s off).
  - sec_cnt increments per tick.
  - Exit to IDLE on the tick where sec_cnt==ALARM_SEC-1, or on the cycle after stop=1, or when alarm_en falls.
  - stop in any other state is ignored.
- buzz is registered: one cycle of latency from the tone flop or the state.
- buzz=0 in IDLE. Unlike the legacy block, there is no latching of the last tone.
- Disable mid-operation: if chime_en drops in PIP or LONG, go to IDLE next cycle and buzz=0 within 2 cycles.
- Time jump (time set, S_in jumps): any change counts as a tick; no multi-second catch-up.
- rst_n asserted mid-operation: immediate IDLE, buzz=0; no event replays after release until a new tick matches.

Test Plan:
- Sim params DIV_LO=4, DIV_HI=3, N_PIPS=5, LONG_SEC=2: step S_in 48..59 at M_in=59 -> buzz toggles every 3 clk only during S=50,52,54,56,58; buzz=0 during 49,51,..,59.
- Roll to M=0, S=0, then S=1, S=2 -> low tone (toggle every 4 clk) for S=0 and S=1; buzz=0 and busy=0 from the tick at S=2.
- alarm_en=1, alarm=07:30; drive 07:30:00 with ALARM_SEC=6 -> tone in seconds 0,2,4, silent in 1,3,5; alarm_active falls at the S=6 tick.
- Alarm active, stop pulse at S=3 -> alarm_active=0 and buzz=0 within 2 cycles; stop pulses in IDLE have no effect.
- Alarm set to 08:00 with chime_en=1, at 08:00:00 -> ALARM pattern, not the LONG tone.
- chime_en=0 through 59:50..00:00 -> buzz stays 0. Separately, rst_n low during PIP -> buzz=0 immediately; after release with S_in unchanged, no pip until the next matching tick.
